// File: rtl/tilemap_read_arbiter.sv
// Round-robin arbiter sharing the single-read-port tilemap memory between the
// tile renderer and the two collision detectors, with bounded grant locking.
module tilemap_read_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 4,
  parameter int LOCK_MAX = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [2:0]        req,
  input  logic [2:0]        lock,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  output logic [2:0]        gnt,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] rdata,
  output logic [2:0]        rvalid,
  output logic              busy
);

  typedef enum logic [1:0] {
    CL0 = 2'd0,
    CL1 = 2'd1,
    CL2 = 2'd2
  } client_t;

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_MAX);

  logic [2:0]       r_gnt;
  logic [2:0]       r_rvalid;
  client_t          r_last;
  logic [CNT_W-1:0] r_lock_cnt;

  logic [2:0]        w_accept_vec;
  logic              w_accept;
  logic              w_own_req;
  logic              w_own_lock;
  logic              w_release;
  logic              w_arbitrate;
  logic              w_pick_valid;
  client_t           w_pick_idx;
  logic [ADDR_W-1:0] w_mem_address;

  assign w_accept_vec = r_gnt & req;
  assign w_accept     = |w_accept_vec;
  assign w_own_req    = |(r_gnt & req);
  assign w_own_lock   = |(r_gnt & lock);

  // With no owner the first two terms are trivially true, so an idle arbiter
  // always re-arbitrates; lock bits of non-owners are masked by r_gnt.
  assign w_release = (!w_own_req && !w_own_lock) ||
                     (w_accept && !w_own_lock) ||
                     (r_lock_cnt == CNT_LAST);
  assign w_arbitrate = (r_gnt == '0) || w_release;

  // Search order last+1, last+2, last puts the releasing owner at the back.
  always_comb begin
    int unsigned cand;
    w_pick_valid = 1'b0;
    w_pick_idx   = CL0;
    cand         = 0;
    for (int unsigned k = 1; k <= 3; k++) begin
      cand = (32'(r_last) + k) % 3;
      if (!w_pick_valid && req[cand[1:0]]) begin
        w_pick_valid = 1'b1;
        w_pick_idx   = client_t'(cand[1:0]);
      end
    end
  end

  always_comb begin
    w_mem_address = '0;
    if (w_accept_vec[0])      w_mem_address = addr0;
    else if (w_accept_vec[1]) w_mem_address = addr1;
    else if (w_accept_vec[2]) w_mem_address = addr2;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_gnt      <= '0;
      r_rvalid   <= '0;
      r_last     <= CL2;
      r_lock_cnt <= '0;
    end else begin
      r_rvalid <= w_accept_vec;
      if (w_arbitrate) begin
        r_lock_cnt <= '0;
        if (w_pick_valid) begin
          r_gnt  <= 3'(3'b001 << w_pick_idx);
          r_last <= w_pick_idx;
        end else begin
          r_gnt <= '0;
        end
      end else if (r_lock_cnt != CNT_MAX) begin
        r_lock_cnt <= r_lock_cnt + 1'b1;
      end
    end
  end

  assign gnt         = r_gnt;
  assign rvalid      = r_rvalid;
  assign busy        = |r_gnt;
  assign mem_address = w_mem_address;
  assign rdata       = mem_q;

endmodule

// File: tb/tb_tilemap_read_arbiter.sv
// Bench for tilemap_read_arbiter: directed vector table, reset corner case and
// randomized traffic against an owner/pointer reference model.
module tb_tilemap_read_arbiter;

  localparam int LOCK_MAX = 8;

  logic        clock;
  logic        resetn;
  logic [2:0]  req;
  logic [2:0]  lock;
  logic [14:0] addr0, addr1, addr2;
  logic [2:0]  gnt;
  logic [14:0] mem_address;
  logic [3:0]  mem_q;
  logic [3:0]  rdata;
  logic [2:0]  rvalid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  tilemap_read_arbiter #(
    .ADDR_W  (15),
    .DATA_W  (4),
    .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .req        (req),
    .lock       (lock),
    .addr0      (addr0),
    .addr1      (addr1),
    .addr2      (addr2),
    .gnt        (gnt),
    .mem_address(mem_address),
    .mem_q      (mem_q),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [3:0] tile_of(input logic [14:0] a);
    if (a == 15'h07D3) return 4'h5;
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ {1'b0, a[14:12]};
  endfunction

  // Tilemap memory: one-cycle synchronous read.
  always @(posedge clock) mem_q <= tile_of(mem_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [14:0] a0, a1, a2;
    logic [14:0] ema;
    logic [2:0]  egnt;
    logic [2:0]  erv;
    logic [3:0]  erd;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input logic [2:0] rq, input logic [2:0] lk,
                      input logic [14:0] a0, input logic [14:0] a1, input logic [14:0] a2,
                      input logic [14:0] ema, input logic [2:0] egnt,
                      input logic [2:0] erv, input logic [14:0] rd_addr);
    vec_t v;
    v.req = rq; v.lock = lk; v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.ema = ema; v.egnt = egnt; v.erv = erv; v.erd = tile_of(rd_addr);
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    req = '0; lock = '0; addr0 = '0; addr1 = '0; addr2 = '0;
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #2 resetn = 1'b1;
    @(negedge clock);
  endtask

  // Reference model: current owner index (-1 = none), round-robin pointer,
  // cycles held, and the pending read-data strobe.
  int          m_own, m_last, m_cnt, m_rv;
  logic [3:0]  m_rd;

  function automatic logic [14:0] addr_of(input int c);
    case (c)
      0: return addr0;
      1: return addr1;
      default: return addr2;
    endcase
  endfunction

  task automatic model_reset();
    m_own = -1; m_last = 2; m_cnt = 0; m_rv = -1; m_rd = '0;
  endtask

  task automatic model_step();
    bit acc, rel;
    int pick;
    acc  = (m_own >= 0) && req[m_own];
    m_rv = acc ? m_own : -1;
    m_rd = acc ? tile_of(addr_of(m_own)) : 4'h0;
    // An owner that is not locking gives the port up; a lock lasts LOCK_MAX cycles.
    rel  = (m_own < 0) || !lock[m_own] || (m_cnt == LOCK_MAX - 1);
    if (rel) begin
      pick = -1;
      for (int k = 1; k <= 3; k++)
        if (pick < 0 && req[(m_last + k) % 3]) pick = (m_last + k) % 3;
      m_cnt = 0;
      m_own = pick;
      if (pick >= 0) m_last = pick;
    end else begin
      m_cnt++;
    end
  endtask

  initial begin
    logic [14:0] x;
    logic [14:0] exp_ma;
    logic [2:0]  exp_g, exp_v;
    int          rrow;

    resetn = 1'b0;
    req = '0; lock = '0; addr0 = '0; addr1 = '0; addr2 = '0;
    #2;
    chk("reset_gnt", 32'(gnt), 32'(3'b000));
    chk("reset_rvalid", 32'(rvalid), 32'(3'b000));
    chk("reset_busy", 32'(busy), 32'(1'b0));
    chk("reset_mem_address", 32'(mem_address), 32'(15'h0));
    do_reset();

    // Directed table: round-robin, single read, lock burst, lock timeout, withdrawal.
    x = 15'h1000;
    addv(3'b111, 3'b000, 15'h0100, 15'h0200, 15'h0300, 15'h0000, 3'b001, 3'b000, 15'h0);
    addv(3'b111, 3'b000, 15'h0100, 15'h0200, 15'h0300, 15'h0100, 3'b010, 3'b001, 15'h0100);
    addv(3'b111, 3'b000, 15'h0100, 15'h0200, 15'h0300, 15'h0200, 3'b100, 3'b010, 15'h0200);
    addv(3'b111, 3'b000, 15'h0100, 15'h0200, 15'h0300, 15'h0300, 3'b001, 3'b100, 15'h0300);
    addv(3'b000, 3'b000, 15'h0100, 15'h0200, 15'h0300, 15'h0000, 3'b000, 3'b000, 15'h0);
    addv(3'b010, 3'b000, 15'h0000, 15'h07D3, 15'h0000, 15'h0000, 3'b010, 3'b000, 15'h0);
    addv(3'b010, 3'b000, 15'h0000, 15'h07D3, 15'h0000, 15'h07D3, 3'b010, 3'b010, 15'h07D3);
    addv(3'b000, 3'b000, 15'h0000, 15'h07D3, 15'h0000, 15'h0000, 3'b000, 3'b000, 15'h0);
    addv(3'b001, 3'b000, 15'h0040, 15'h0000, 15'h0000, 15'h0000, 3'b001, 3'b000, 15'h0);
    addv(3'b011, 3'b000, 15'h0040, x,        15'h0000, 15'h0040, 3'b010, 3'b001, 15'h0040);
    addv(3'b011, 3'b010, 15'h0040, x + 15'd1,    15'h0, x + 15'd1,    3'b010, 3'b010, x + 15'd1);
    addv(3'b011, 3'b010, 15'h0040, x - 15'd1,    15'h0, x - 15'd1,    3'b010, 3'b010, x - 15'd1);
    addv(3'b011, 3'b010, 15'h0040, x + 15'd2000, 15'h0, x + 15'd2000, 3'b010, 3'b010, x + 15'd2000);
    addv(3'b011, 3'b000, 15'h0040, x - 15'd2000, 15'h0, x - 15'd2000, 3'b001, 3'b010, x - 15'd2000);
    addv(3'b001, 3'b000, 15'h0050, 15'h0000, 15'h0000, 15'h0050, 3'b001, 3'b001, 15'h0050);
    addv(3'b101, 3'b000, 15'h0060, 15'h0000, 15'h2000, 15'h0060, 3'b100, 3'b001, 15'h0060);
    for (int i = 0; i < LOCK_MAX; i++)
      addv(3'b101, 3'b100, 15'h0060, 15'h0000, 15'(15'h2000 + i), 15'(15'h2000 + i),
           (i < LOCK_MAX - 1) ? 3'b100 : 3'b001, 3'b100, 15'(15'h2000 + i));
    addv(3'b000, 3'b000, 15'h0060, 15'h0000, 15'h2000, 15'h0000, 3'b000, 3'b000, 15'h0);
    addv(3'b001, 3'b001, 15'h0070, 15'h0000, 15'h0700, 15'h0000, 3'b001, 3'b000, 15'h0);
    addv(3'b101, 3'b001, 15'h0070, 15'h0000, 15'h0700, 15'h0070, 3'b001, 3'b001, 15'h0070);
    addv(3'b001, 3'b001, 15'h0070, 15'h0000, 15'h0700, 15'h0070, 3'b001, 3'b001, 15'h0070);
    addv(3'b001, 3'b000, 15'h0070, 15'h0000, 15'h0700, 15'h0070, 3'b001, 3'b001, 15'h0070);
    addv(3'b000, 3'b000, 15'h0070, 15'h0000, 15'h0700, 15'h0000, 3'b000, 3'b000, 15'h0);

    foreach (tbl[i]) begin
      req = tbl[i].req; lock = tbl[i].lock;
      addr0 = tbl[i].a0; addr1 = tbl[i].a1; addr2 = tbl[i].a2;
      #1;
      chk($sformatf("vec%0d_mem_address", i), 32'(mem_address), 32'(tbl[i].ema));
      @(posedge clock); #1;
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].egnt));
      chk($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].erv));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(|tbl[i].egnt));
      if (tbl[i].erv != 3'b000)
        chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(tbl[i].erd));
    end

    // Asynchronous reset in the middle of a locked burst.
    req = 3'b010; lock = 3'b010; addr1 = 15'h0123;
    @(posedge clock); #1;
    chk("burst_gnt", 32'(gnt), 32'(3'b010));
    @(posedge clock); #1;
    chk("burst_rvalid", 32'(rvalid), 32'(3'b010));
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'(3'b000));
    chk("async_rst_rvalid", 32'(rvalid), 32'(3'b000));
    chk("async_rst_mem_address", 32'(mem_address), 32'(15'h0));
    chk("async_rst_busy", 32'(busy), 32'(1'b0));
    req = '0; lock = '0;
    @(posedge clock);
    #2 resetn = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_gnt", 32'(gnt), 32'(3'b000));
    chk("post_rst_rvalid", 32'(rvalid), 32'(3'b000));
    req = 3'b001;
    @(posedge clock); #1;
    chk("post_rst_first_gnt", 32'(gnt), 32'(3'b001));
    chk("post_rst_late_rvalid", 32'(rvalid), 32'(3'b000));

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      req   = 3'($urandom_range(0, 7));
      lock  = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      addr0 = 15'($urandom); addr1 = 15'($urandom); addr2 = 15'($urandom);
      #1;
      exp_ma = (m_own >= 0 && req[m_own]) ? addr_of(m_own) : 15'h0;
      chk("rnd_mem_address", 32'(mem_address), 32'(exp_ma));
      model_step();
      @(posedge clock); #1;
      exp_g = (m_own >= 0) ? 3'(1 << m_own) : 3'b000;
      exp_v = (m_rv >= 0) ? 3'(1 << m_rv) : 3'b000;
      chk("rnd_gnt", 32'(gnt), 32'(exp_g));
      chk("rnd_rvalid", 32'(rvalid), 32'(exp_v));
      chk("rnd_busy", 32'(busy), 32'(exp_g != 3'b000));
      if (m_rv >= 0) chk("rnd_rdata", 32'(rdata), 32'(m_rd));
      rrow = cyc;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
